// File: rtl/controlador_jogo_pkg.sv
// Shared codes for the battleship sequencer: state encoding, mode switch values
// and LED-matrix geometry.
package controlador_jogo_pkg;

    typedef enum logic [2:0] {
        DESLIGADO  = 3'd0,
        PREPARACAO = 3'd1,
        PRONTO     = 3'd2,
        ATAQUE     = 3'd3,
        AGUARDA    = 3'd4,
        FIM        = 3'd5
    } estado_t;

    localparam logic [1:0] MODO_DESL = 2'b00;
    localparam logic [1:0] MODO_PREP = 2'b01;
    localparam logic [1:0] MODO_ATQ  = 2'b10;

    localparam int NUM_COLUNAS = 5;
    localparam int NUM_LINHAS  = 7;
    localparam int NUM_CELULAS = NUM_COLUNAS * NUM_LINHAS;

    // Both 00 and 11 switch the game off.
    function automatic logic modo_desligado(input logic [1:0] modo);
        return (modo == MODO_DESL) || (modo == 2'b11);
    endfunction

endpackage

// File: rtl/controlador_jogo_if.sv
// Handshake between the sequencer and the map selector / attack manager.
interface controlador_jogo_if;

    logic       confirmar_mapa;
    logic       confirmar_ataque;
    logic       mapa_travado;
    logic [5:0] total_alvos;
    logic       resultado_valido;
    logic       acerto;
    logic       repetido;

    modport master (
        output confirmar_mapa,
        output confirmar_ataque,
        output mapa_travado,
        input  total_alvos,
        input  resultado_valido,
        input  acerto,
        input  repetido
    );

    modport slave (
        input  confirmar_mapa,
        input  confirmar_ataque,
        input  mapa_travado,
        output total_alvos,
        output resultado_valido,
        output acerto,
        output repetido
    );

endinterface

// File: rtl/debounce_botao.sv
// Confirm button conditioning: 2-flop synchronizer, down-counting debouncer and
// a one-cycle pulse on the accepted press (high-to-low) transition.
module debounce_botao #(
    parameter int DEBOUNCE_CICLOS = 8
) (
    input  logic clock,
    input  logic reset_n,
    input  logic btn_n,
    output logic pressionado
);

    localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);
    localparam logic [CW-1:0] CARGA = CW'(DEBOUNCE_CICLOS - 1);

    logic          sinc_1;
    logic          sinc_2;
    logic          nivel_aceito;
    logic [CW-1:0] contador;

    // Any sample equal to the accepted level restarts the count, so a bounce
    // never accumulates towards acceptance.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sinc_1       <= 1'b1;
            sinc_2       <= 1'b1;
            nivel_aceito <= 1'b1;
            contador     <= CARGA;
            pressionado  <= 1'b0;
        end else begin
            sinc_1      <= btn_n;
            sinc_2      <= sinc_1;
            pressionado <= 1'b0;
            if (sinc_2 == nivel_aceito) begin
                contador <= CARGA;
            end else if (contador == '0) begin
                nivel_aceito <= sinc_2;
                contador     <= CARGA;
                pressionado  <= ~sinc_2;
            end else begin
                contador <= contador - 1'b1;
            end
        end
    end

endmodule

// File: rtl/controlador_jogo.sv
// Battleship game sequencer: mode/button decoding, attack handshake, shot and
// hit counting, victory/defeat decision.
//
// state      | meaning
// DESLIGADO  | game off, all game registers cleared, matrix dark
// PREPARACAO | map editing; press locks the map (also pause state)
// PRONTO     | map locked, waiting for attack mode
// ATAQUE     | waiting for a press to fire a shot
// AGUARDA    | shot issued, waiting for the attack manager's result
// FIM        | game over, vitoria/derrota held until switched off
module controlador_jogo
    import controlador_jogo_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = 8,
    parameter int MAX_TENTATIVAS  = 20
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [1:0]                modo,
    input  logic                      btn_confirmar_n,
    controlador_jogo_if.master        atq,
    output logic [2:0]                estado,
    output logic                      ligar_matriz,
    output logic [4:0]                tentativas_restantes,
    output logic [5:0]                acertos,
    output logic                      vitoria,
    output logic                      derrota
);

    localparam logic [4:0] TENT_CARGA = 5'(MAX_TENTATIVAS);
    localparam logic [5:0] ACERTOS_MAX = 6'(NUM_CELULAS);

    logic       pressionado;
    estado_t    estado_q, estado_d;
    logic [4:0] tent_q, tent_d, tent_pos;
    logic [5:0] acertos_q, acertos_d, acertos_pos;
    logic       vitoria_q, vitoria_d;
    logic       derrota_q, derrota_d;
    logic       travado_q, travado_d;
    logic       conf_mapa, conf_ataque;

    debounce_botao #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_debounce (
        .clock       (clock),
        .reset_n     (reset_n),
        .btn_n       (btn_confirmar_n),
        .pressionado (pressionado)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            estado_q  <= DESLIGADO;
            tent_q    <= TENT_CARGA;
            acertos_q <= '0;
            vitoria_q <= 1'b0;
            derrota_q <= 1'b0;
            travado_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            tent_q    <= tent_d;
            acertos_q <= acertos_d;
            vitoria_q <= vitoria_d;
            derrota_q <= derrota_d;
            travado_q <= travado_d;
        end
    end

    always_comb begin
        estado_d    = estado_q;
        tent_d      = tent_q;
        acertos_d   = acertos_q;
        vitoria_d   = vitoria_q;
        derrota_d   = derrota_q;
        travado_d   = travado_q;
        tent_pos    = tent_q;
        acertos_pos = acertos_q;
        conf_mapa   = 1'b0;
        conf_ataque = 1'b0;

        if (modo_desligado(modo)) begin
            estado_d = DESLIGADO;
        end else begin
            case (estado_q)
                DESLIGADO: begin
                    if (modo == MODO_PREP) estado_d = PREPARACAO;
                end
                PREPARACAO: begin
                    // With the map already locked this is a pause: attack
                    // mode resumes without reloading the counters.
                    if (modo == MODO_PREP && pressionado && !travado_q) begin
                        conf_mapa = 1'b1;
                        travado_d = 1'b1;
                        estado_d  = PRONTO;
                    end else if (modo == MODO_ATQ && travado_q) begin
                        estado_d = ATAQUE;
                    end
                end
                PRONTO: begin
                    if (modo == MODO_ATQ) begin
                        tent_d    = TENT_CARGA;
                        acertos_d = '0;
                        if (atq.total_alvos == '0) begin
                            vitoria_d = 1'b1;
                            estado_d  = FIM;
                        end else begin
                            estado_d = ATAQUE;
                        end
                    end
                end
                ATAQUE: begin
                    if (modo == MODO_PREP) begin
                        estado_d = PREPARACAO;
                    end else if (pressionado) begin
                        conf_ataque = 1'b1;
                        estado_d    = AGUARDA;
                    end
                end
                AGUARDA: begin
                    if (modo == MODO_PREP) begin
                        estado_d = PREPARACAO;
                    end else if (atq.resultado_valido) begin
                        if (atq.repetido) begin
                            estado_d = ATAQUE;
                        end else begin
                            tent_pos    = (tent_q != '0) ? tent_q - 1'b1 : tent_q;
                            acertos_pos = (atq.acerto && acertos_q < ACERTOS_MAX) ?
                                          acertos_q + 1'b1 : acertos_q;
                            tent_d      = tent_pos;
                            acertos_d   = acertos_pos;
                            if (acertos_pos == atq.total_alvos) begin
                                vitoria_d = 1'b1;
                                estado_d  = FIM;
                            end else if (tent_pos == '0) begin
                                derrota_d = 1'b1;
                                estado_d  = FIM;
                            end else begin
                                estado_d = ATAQUE;
                            end
                        end
                    end
                end
                FIM: begin
                end
                default: estado_d = DESLIGADO;
            endcase
        end

        if (estado_d == DESLIGADO) begin
            tent_d    = TENT_CARGA;
            acertos_d = '0;
            vitoria_d = 1'b0;
            derrota_d = 1'b0;
            travado_d = 1'b0;
        end
    end

    assign estado               = estado_q;
    assign ligar_matriz         = estado_q inside {PREPARACAO, PRONTO, ATAQUE, AGUARDA, FIM};
    assign tentativas_restantes = tent_q;
    assign acertos              = acertos_q;
    assign vitoria              = vitoria_q;
    assign derrota              = derrota_q;
    assign atq.confirmar_mapa   = conf_mapa;
    assign atq.confirmar_ataque = conf_ataque;
    assign atq.mapa_travado     = travado_q;

endmodule

// File: tb/tb_controlador_jogo.sv
// Directed bench for controlador_jogo with a reference model and a result scoreboard.
module tb_controlador_jogo;
    import controlador_jogo_pkg::*;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] modo = 2'b00;
    logic       btn_confirmar_n = 1'b1;
    logic [2:0] estado;
    logic       ligar_matriz;
    logic [4:0] tentativas_restantes;
    logic [5:0] acertos;
    logic       vitoria;
    logic       derrota;

    controlador_jogo_if atq_if ();

    controlador_jogo #(.DEBOUNCE_CICLOS(8), .MAX_TENTATIVAS(20)) dut (
        .clock                (clock),
        .reset_n              (reset_n),
        .modo                 (modo),
        .btn_confirmar_n      (btn_confirmar_n),
        .atq                  (atq_if),
        .estado               (estado),
        .ligar_matriz         (ligar_matriz),
        .tentativas_restantes (tentativas_restantes),
        .acertos              (acertos),
        .vitoria              (vitoria),
        .derrota              (derrota)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] estado;
        logic [4:0] tent;
        logic [5:0] ac;
        logic       vit;
        logic       der;
    } esperado_t;

    esperado_t sb[$];
    int n_chk = 0;
    int n_fail = 0;

    int   m_estado, m_tent, m_ac, m_total;
    logic m_vit, m_der, m_trav;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_estado = 0; m_tent = 20; m_ac = 0;
        m_vit = 1'b0; m_der = 1'b0; m_trav = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_estado"}, estado, 0);
        chk({tag, "_ligar"}, ligar_matriz, 0);
        chk({tag, "_tent"}, tentativas_restantes, 20);
        chk({tag, "_acertos"}, acertos, 0);
        chk({tag, "_vitoria"}, vitoria, 0);
        chk({tag, "_derrota"}, derrota, 0);
        chk({tag, "_travado"}, atq_if.mapa_travado, 0);
        chk({tag, "_conf_mapa"}, atq_if.confirmar_mapa, 0);
        chk({tag, "_conf_atq"}, atq_if.confirmar_ataque, 0);
    endtask

    task automatic set_modo(input logic [1:0] m);
        modo = m;
        tick();
        if (m == 2'b00 || m == 2'b11) m_reset();
        else begin
            case (m_estado)
                0: if (m == MODO_PREP) m_estado = 1;
                1: if (m == MODO_ATQ && m_trav) m_estado = 3;
                2: if (m == MODO_ATQ) begin
                       m_tent = 20; m_ac = 0;
                       if (m_total == 0) begin m_estado = 5; m_vit = 1'b1; end
                       else m_estado = 3;
                   end
                3, 4: if (m == MODO_PREP) m_estado = 1;
                default: ;
            endcase
        end
        chk("modo_estado", estado, m_estado);
        chk("modo_tent", tentativas_restantes, m_tent);
        chk("modo_acertos", acertos, m_ac);
        chk("modo_travado", atq_if.mapa_travado, m_trav);
        chk("modo_ligar", ligar_matriz, m_estado != 0);
    endtask

    // Press and hold, then release; counts every command pulse in the window.
    task automatic press(input string tag);
        int  lat, n_mapa, n_atq;
        logic exp_mapa, exp_atq;
        exp_mapa = (m_estado == 1 && modo == MODO_PREP && !m_trav);
        exp_atq  = (m_estado == 3 && modo == MODO_ATQ);
        lat = -1; n_mapa = 0; n_atq = 0;
        btn_confirmar_n = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (atq_if.confirmar_mapa)   begin n_mapa++; if (lat < 0) lat = i; end
            if (atq_if.confirmar_ataque) begin n_atq++;  if (lat < 0) lat = i; end
        end
        btn_confirmar_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (atq_if.confirmar_mapa)   n_mapa++;
            if (atq_if.confirmar_ataque) n_atq++;
        end
        if (exp_mapa) begin m_trav = 1'b1; m_estado = 2; end
        if (exp_atq) m_estado = 4;
        chk({tag, "_n_mapa"}, n_mapa, exp_mapa);
        chk({tag, "_n_atq"}, n_atq, exp_atq);
        chk({tag, "_estado"}, estado, m_estado);
        if (exp_mapa || exp_atq) chk({tag, "_latencia"}, lat, 10);
    endtask

    task automatic resultado(input logic a, input logic r);
        esperado_t e, got;
        if (m_estado == 4) begin
            if (r) m_estado = 3;
            else begin
                if (m_tent > 0) m_tent--;
                if (a && m_ac < 35) m_ac++;
                if (m_ac == m_total) begin m_estado = 5; m_vit = 1'b1; end
                else if (m_tent == 0) begin m_estado = 5; m_der = 1'b1; end
                else m_estado = 3;
            end
        end
        e.estado = 3'(m_estado); e.tent = 5'(m_tent); e.ac = 6'(m_ac);
        e.vit = m_vit; e.der = m_der;
        sb.push_back(e);
        atq_if.resultado_valido = 1'b1; atq_if.acerto = a; atq_if.repetido = r;
        tick();
        atq_if.resultado_valido = 1'b0; atq_if.acerto = 1'b0; atq_if.repetido = 1'b0;
        got = sb.pop_front();
        chk("res_estado", estado, got.estado);
        chk("res_tent", tentativas_restantes, got.tent);
        chk("res_acertos", acertos, got.ac);
        chk("res_vitoria", vitoria, got.vit);
        chk("res_derrota", derrota, got.der);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_bounce;
        atq_if.total_alvos = 6'd0;
        atq_if.resultado_valido = 1'b0;
        atq_if.acerto = 1'b0;
        atq_if.repetido = 1'b0;
        m_reset();
        m_total = 0;
        tick(); tick();
        chk_reset("reset");
        reset_n = 1'b1;
        tick();

        // Map confirmation after a bouncing press
        set_modo(MODO_PREP);
        n_bounce = 0;
        for (int i = 0; i < 6; i++) begin
            btn_confirmar_n = (i % 2 != 0);
            tick();
            if (atq_if.confirmar_mapa) n_bounce++;
        end
        chk("bounce_no_pulse", n_bounce, 0);
        press("mapa");
        chk("mapa_travado", atq_if.mapa_travado, 1);
        press("pronto_ignora");

        // Victory: 2 targets, one repeated cell, one stray result, two hits
        atq_if.total_alvos = 6'd2; m_total = 2;
        set_modo(MODO_ATQ);
        press("tiro1");
        press("aguarda_ignora");
        resultado(1'b0, 1'b1);
        resultado(1'b1, 1'b0);
        press("tiro2");
        resultado(1'b1, 1'b0);
        press("tiro3");
        resultado(1'b1, 1'b0);
        chk("vit_tent18", tentativas_restantes, 18);
        press("fim_ignora");
        set_modo(MODO_DESL);
        chk_reset("desl_fim");

        // Defeat: 20 misses with a pause after the fifth
        set_modo(MODO_PREP);
        press("mapa2");
        atq_if.total_alvos = 6'd3; m_total = 3;
        set_modo(MODO_ATQ);
        for (int i = 1; i <= 20; i++) begin
            press("tiro_derrota");
            resultado(1'b0, 1'b0);
            if (i == 5) begin
                set_modo(MODO_PREP);
                set_modo(MODO_ATQ);
            end
        end
        chk("derrota", derrota, 1);
        press("tiro_21");

        // Switch off in AGUARDA in the same cycle as a press pulse
        set_modo(MODO_DESL);
        set_modo(MODO_PREP);
        press("mapa3");
        atq_if.total_alvos = 6'd4; m_total = 4;
        set_modo(MODO_ATQ);
        press("tiro4");
        btn_confirmar_n = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        modo = MODO_DESL;
        tick();
        m_reset();
        chk_reset("desl_simult");
        btn_confirmar_n = 1'b1;
        for (int i = 0; i < 12; i++) tick();

        // Reset in the middle of a game
        set_modo(MODO_PREP);
        press("mapa4");
        atq_if.total_alvos = 6'd2; m_total = 2;
        set_modo(MODO_ATQ);
        press("tiro5");
        resultado(1'b1, 1'b0);
        reset_n = 1'b0;
        tick();
        m_reset();
        chk_reset("reset_meio");
        reset_n = 1'b1;
        tick();
        chk("pos_reset_estado", estado, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
